ula_issue: RTL and testbench

//  Operand-issue and writeback sequencer for the 8-bit ALU (ula).
//  - Accepts one ALU instruction at a time via a valid/ready handshake.
//  - Reads operands from an internal register file and drives the ALU inputs from registers.
//  - Captures the ALU result and writes it back.
//  - Sits between the instruction decoder (upstream) and the ALU (downstream, combinational).

---
 rtl/ula_issue_if.sv | 28 ++
 rtl/ula_issue.sv | 116 +++++++++++
 tb/tb_ula_issue.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_issue_if.sv
// Handshake and ALU-facing bus of the ula_issue sequencer.
// The slave modport is the sequencer; the master modport is the decoder/ALU side.
interface ula_issue_if #(
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [7:0]    alu_ina;
    logic [7:0]    alu_inb;
    logic [15:0]   alu_op;
    logic [7:0]    alu_result;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, alu_result,
        output in_ready, alu_ina, alu_inb, alu_op
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, alu_result,
        input  in_ready, alu_ina, alu_inb, alu_op
    );
endinterface

// File: rtl/ula_issue.sv
// Operand-issue and writeback sequencer for the 8-bit ula ALU (IDLE -> EXEC -> WB).
// Optional macro ULA_ISSUE_FLAGS_EN adds zero/negative flag outputs captured at writeback.
module ula_issue #(
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ula_issue_if.slave               bus,
    output logic                     done,
    output logic                     illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [7:0]               dbg_data
`ifdef ULA_ISSUE_FLAGS_EN
    ,
    output logic                     flag_z,
    output logic                     flag_n
`endif
);
    localparam int AW = $clog2(NREGS);
    localparam logic [2:0] OP_ILL = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_ILL  = 2'd3
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          done_q;
    logic          illegal_q;
    logic [7:0]    ina_q;
    logic [7:0]    inb_q;
    logic [2:0]    aop_q;
    logic [AW-1:0] rd_q;
    logic [7:0]    rf_q [NREGS];
`ifdef ULA_ISSUE_FLAGS_EN
    logic          flag_z_q;
    logic          flag_n_q;
`endif

    logic          accept_d;
    logic          is_ill_d;

    assign accept_d = bus.in_valid & in_ready_q;
    assign is_ill_d = (bus.in_op == OP_ILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            ina_q      <= 8'h00;
            inb_q      <= 8'h00;
            aop_q      <= 3'b000;
            rd_q       <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= 8'h00;
`ifdef ULA_ISSUE_FLAGS_EN
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        in_ready_q <= 1'b0;
                        rd_q       <= bus.in_rd;
                        // An illegal op leaves the ALU drive untouched.
                        if (is_ill_d) begin
                            illegal_q <= 1'b1;
                            state_q   <= S_ILL;
                        end else begin
                            ina_q   <= rf_q[bus.in_rs1];
                            inb_q   <= rf_q[bus.in_rs2];
                            aop_q   <= bus.in_op;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    done_q  <= 1'b1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    rf_q[rd_q] <= bus.alu_result;
`ifdef ULA_ISSUE_FLAGS_EN
                    flag_z_q   <= (bus.alu_result == 8'h00);
                    flag_n_q   <= bus.alu_result[7];
`endif
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.alu_ina  = ina_q;
    assign bus.alu_inb  = inb_q;
    assign bus.alu_op   = {13'b0, aop_q};
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign dbg_data     = rf_q[dbg_addr];
`ifdef ULA_ISSUE_FLAGS_EN
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
`endif
endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue with a small behavioural model of the ula ALU.
// Build with ULA_ISSUE_FLAGS_EN defined to also check the flag outputs.
module tb_ula_issue;
    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic       illegal;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef ULA_ISSUE_FLAGS_EN
    logic       flag_z;
    logic       flag_n;
`endif
    logic       ovr_en;
    logic [7:0] ovr_val;
    int         checks = 0;
    int         errors = 0;

    ula_issue_if #(.NREGS(8)) bus ();

    ula_issue #(.NREGS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ULA_ISSUE_FLAGS_EN
        ,
        .flag_z   (flag_z),
        .flag_n   (flag_n)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return a - b;
            3'b111:  return (a > b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // The bench plays the combinational ALU; ovr_en lets preloads write arbitrary constants.
    assign bus.alu_result = ovr_en ? ovr_val : alu_model(bus.alu_op[2:0], bus.alu_ina, bus.alu_inb);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake one instruction; returns in cycle 1 (one edge after acceptance).
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        step();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b010;
        bus.in_rd    = ~rd;
        bus.in_rs1   = ~rs1;
        bus.in_rs2   = ~rs2;
    endtask

    // Writes a constant into a register; returns in the cycle after writeback.
    task automatic preload(input logic [2:0] rd, input logic [7:0] val);
        ovr_en  = 1'b1;
        ovr_val = val;
        send(3'b000, rd, 3'd0, 3'd0);
        step();
        step();
        ovr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/done/illegal=%b%b%b required 100", bus.in_ready, done, illegal);
        end
        checks++;
        if (bus.alu_op !== 16'h0000 || bus.alu_ina !== 8'h00 || bus.alu_inb !== 8'h00) begin
            errors++;
            $display("FAIL reset_alu: op=%h ina=%h inb=%h required 0", bus.alu_op, bus.alu_ina, bus.alu_inb);
        end
`ifdef ULA_ISSUE_FLAGS_EN
        checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: z=%b n=%b required 00", flag_z, flag_n);
        end
`endif
        // Abort an instruction mid-EXEC.
        preload(3'd1, 8'h11);
        preload(3'd2, 8'h22);
        send(3'b010, 3'd3, 3'd1, 3'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort_ready: in_ready=%b required 1", bus.in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_abort_rf%0d: dbg_data=%h required 00", i, dbg_data);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort_done: done=%b required 0", done);
            end
            step();
        end
    endtask

    task automatic test_add();
        preload(3'd1, 8'd5);
        preload(3'd2, 8'd3);
        send(3'b010, 3'd3, 3'd1, 3'd2);
        checks++;
        if (bus.alu_op !== 16'h0002 || bus.alu_ina !== 8'd5 || bus.alu_inb !== 8'd3) begin
            errors++;
            $display("FAIL add_drive: op=%h ina=%h inb=%h required 0002 05 03", bus.alu_op, bus.alu_ina, bus.alu_inb);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_c1: ready=%b done=%b required 0 0", bus.in_ready, done);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL add_done: done=%b required 1", done);
        end
        step();
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 8'd8 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_wb: r3=%h done=%b required 08 0", dbg_data, done);
        end
    endtask

    task automatic test_back_to_back();
        send(3'b010, 3'd3, 3'd1, 3'd2);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap1: in_ready=%b required 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap2: in_ready=%b required 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b required 1", bus.in_ready);
        end
        send(3'b110, 3'd4, 3'd3, 3'd1);
        checks++;
        if (bus.alu_ina !== 8'd8 || bus.alu_inb !== 8'd5 || bus.alu_op !== 16'h0006) begin
            errors++;
            $display("FAIL b2b_hazard: ina=%h inb=%h op=%h required 08 05 0006", bus.alu_ina, bus.alu_inb, bus.alu_op);
        end
        step();
        step();
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 8'd3) begin
            errors++;
            $display("FAIL b2b_r4: r4=%h required 03", dbg_data);
        end
    endtask

    task automatic test_wrap();
        preload(3'd1, 8'hFF);
        preload(3'd2, 8'h01);
        send(3'b010, 3'd5, 3'd1, 3'd2);
        step();
        step();
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 8'h00) begin
            errors++;
            $display("FAIL wrap_add: r5=%h required 00", dbg_data);
        end
`ifdef ULA_ISSUE_FLAGS_EN
        checks++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
            errors++;
            $display("FAIL wrap_add_flags: z=%b n=%b required 1 0", flag_z, flag_n);
        end
`endif
        send(3'b110, 3'd6, 3'd5, 3'd2);
        step();
        step();
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_sub: r6=%h required FF", dbg_data);
        end
`ifdef ULA_ISSUE_FLAGS_EN
        checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b1) begin
            errors++;
            $display("FAIL wrap_sub_flags: z=%b n=%b required 0 1", flag_z, flag_n);
        end
`endif
    endtask

    task automatic test_illegal();
        send(3'b011, 3'd6, 3'd1, 3'd2);
        checks++;
        if (illegal !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ill_c1: illegal=%b done=%b ready=%b required 1 0 0", illegal, done, bus.in_ready);
        end
        checks++;
        if (bus.alu_op !== 16'h0006 || bus.alu_ina !== 8'h00 || bus.alu_inb !== 8'h01) begin
            errors++;
            $display("FAIL ill_drive: op=%h ina=%h inb=%h required 0006 00 01", bus.alu_op, bus.alu_ina, bus.alu_inb);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || illegal !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ill_c2: ready=%b illegal=%b done=%b required 1 0 0", bus.in_ready, illegal, done);
        end
        step();
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'hFF || done !== 1'b0) begin
            errors++;
            $display("FAIL ill_rd: r6=%h done=%b required FF 0", dbg_data, done);
        end
`ifdef ULA_ISSUE_FLAGS_EN
        checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b1) begin
            errors++;
            $display("FAIL ill_flags: z=%b n=%b required 0 1", flag_z, flag_n);
        end
`endif
    endtask

    task automatic test_logic();
        logic [2:0] ops [3];
        logic [7:0] exp [3];
        ops[0] = 3'b111; exp[0] = 8'h01;
        ops[1] = 3'b100; exp[1] = 8'h09;
        ops[2] = 3'b101; exp[2] = 8'hFB;
        preload(3'd1, 8'h09);
        preload(3'd2, 8'h04);
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 3'd7, 3'd1, 3'd2);
            checks++;
            if (bus.alu_op !== {13'b0, ops[i]}) begin
                errors++;
                $display("FAIL logic_op%0d: alu_op=%h required %h", i, bus.alu_op, {13'b0, ops[i]});
            end
            step();
            step();
            dbg_addr = 3'd7;
            #1;
            checks++;
            if (dbg_data !== exp[i]) begin
                errors++;
                $display("FAIL logic_res%0d: r7=%h required %h", i, dbg_data, exp[i]);
            end
`ifdef ULA_ISSUE_FLAGS_EN
            checks++;
            if (flag_n !== exp[i][7] || flag_z !== 1'b0) begin
                errors++;
                $display("FAIL logic_flags%0d: z=%b n=%b required 0 %b", i, flag_z, flag_n, exp[i][7]);
            end
`endif
        end
    endtask

    initial begin
        rst          = 1'b1;
        ovr_en       = 1'b0;
        ovr_val      = 8'h00;
        dbg_addr     = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b000;
        bus.in_rd    = 3'd0;
        bus.in_rs1   = 3'd0;
        bus.in_rs2   = 3'd0;
        test_reset();
        test_add();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_logic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
